spi_slave_ctrl: RTL and testbench
=================================

# spi_slave_ctrl

Parametrised SPI slave for the actuator controller's host link, the successor to the fixed 32-bit, mode-0-only shift register. It oversamples the external SPI pins with the system `clock`. It supports all four SPI modes, a configurable word width, MSB- or LSB-first ordering and back-to-back words within one frame. Buffered TX and RX handshakes with sticky error flags connect it to the register/command layer.

## Interface
- `WIDTH`, 32: word length in bits, 8–64.
- `CPOL`, 0: SCLK idle level.
- `CPHA`, 0: 0 means sample on the leading edge; 1 means sample on the trailing edge.
- `MSB_FIRST`, 1: 1 shifts bit `WIDTH-1` first; 0 shifts bit 0 first.
- `SYNC_STAGES`, 3: synchroniser depth on `sclk`, `ss_n` and `mosi`; minimum 2.

Ports:
- `clock`, input, 1: system clock. All logic is on its rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `sclk`, input, 1: SPI clock pin, asynchronous.
- `ss_n`, input, 1: SPI slave select pin, active low, asynchronous.
- `mosi`, input, 1: SPI data in, asynchronous.
- `miso`, output, 1: SPI data out.
- `miso_oe`, output, 1: MISO output enable; high while the synchronised `ss_n` is low.
- `tx_data`, input, WIDTH: next word to transmit.
- `tx_valid`, input, 1: `tx_data` is offered.
- `tx_ready`, output, 1: TX buffer is empty; the word is accepted when `tx_valid && tx_ready`.
- `rx_data`, output, WIDTH: last received word.
- `rx_valid`, output, 1: `rx_data` is unread.
- `rx_ready`, input, 1: consumer takes `rx_data`; clears `rx_valid`.
- `frame_active`, output, 1: synchronised `ss_n` is low.
- `overrun`, output, 1: sticky; a word completed while `rx_valid` was high.
- `underrun`, output, 1: sticky; a word started with the TX buffer empty.
- `aborted`, output, 1: sticky; `ss_n` rose with a partial word.
- `clear_flags`, input, 1: synchronous one-cycle clear of all three sticky flags.

## Operation
- Synchronisers: the `sclk` chain resets to CPOL; the `ss_n` chain resets to 1; the `mosi` chain resets to 0. Edges are detected between the last two stages.
- Edge roles: sample edge = rising when CPOL==CPHA, otherwise falling. Drive edge is the opposite edge. Edges are ignored while the synchronised `ss_n` is high.
- FSM states:
  - IDLE → START when the synchronised `ss_n` falls.
  - START lasts one cycle. It loads `tx_shift` from the TX buffer and empties the buffer. If the buffer is empty it loads all-zeros and sets `underrun`. It clears the bit counter, then → SHIFT.
  - SHIFT → IDLE when the synchronised `ss_n` rises. If the bit counter is nonzero, the partial word is discarded and `aborted` is set.
- RX: each sample edge shifts the synchronised `mosi` into `rx_shift` (direction per MSB_FIRST) and increments the bit counter, width `$clog2(WIDTH)`.
- Word completion is the WIDTH-th sample: the counter wraps to 0; `rx_data` is loaded with the full word; `rx_valid` is set. If `rx_valid` was already high and `rx_ready` is low in the same cycle, `overrun` is set and the old word is overwritten.
- TX: `miso` = `tx_shift[WIDTH-1]` when MSB_FIRST, otherwise `tx_shift[0]`. It is 0 in IDLE.
- A drive edge advances `tx_shift` one bit only when armed. The armed flag is set by a sample edge and cleared by a drive edge, so for CPHA=1 the first leading edge of a word does not shift.
- Word boundary reload (buffer, or zeros plus `underrun`, as in START):
  - CPHA=0: at the drive edge following word completion.
  - CPHA=1: at word completion.
- TX buffer: one entry. `tx_ready` = buffer empty. A load from the buffer and a new accept in the same cycle is legal; the buffer ends full with the new word.
- `rx_ready` while `rx_valid` is high clears `rx_valid` next cycle, unless a word completes that same cycle, in which case `rx_valid` stays high and `overrun` is not set.
- `clear_flags` in the same cycle as a flag-setting event: the set wins.

## Timing
- Reset values:
  - `miso`=0, `miso_oe`=0, `frame_active`=0.
  - `tx_ready`=1, `rx_valid`=0, `rx_data`=0.
  - `overrun`=`underrun`=`aborted`=0.
  - FSM in IDLE, both shift registers 0.
- Reset asserted mid-frame returns everything to reset values immediately. The frame resumes only after a fresh `ss_n` fall.
- Latency:
  - Pin edge to internal edge detect: SYNC_STAGES clocks.
  - `rx_valid` rises 1 clock after the WIDTH-th sample edge is detected.
  - `miso` changes 1 clock after drive-edge detect.
- SCLK constraint: high and low phases ≥ SYNC_STAGES+2 clock periods. `ss_n` fall to first SCLK edge ≥ SYNC_STAGES+2 clocks.
- `tx_ready`, `rx_valid` and the flags are registered outputs.

## Test plan
- Mode 0, WIDTH=32, MSB_FIRST: preload `tx_data`=0xDEADBEEF; master sends 0x12345678 → `rx_data`=0x12345678 with one `rx_valid`; master reads 0xDEADBEEF; `underrun`=0.
- Mode 3, WIDTH=16, LSB first: two back-to-back words 0xA5A5 and 0x0F0F in one frame, `rx_ready` tied high → two `rx_valid` pulses carrying those values; MISO returns both buffered words.
- Overrun: `rx_ready`=0 across two 32-bit words 0x1, 0x2 → `rx_data`=0x2, `overrun`=1; `clear_flags` → 0.
- Underrun/abort: no TX word loaded, then `ss_n` raised after 10 bits → MISO all zeros, `underrun`=1, `aborted`=1, `rx_valid` stays 0.
- Reset mid-word: `reset_n` low after 5 bits of mode 1 → all outputs at reset values; next full frame of 0xCAFEF00D is received correctly.
- Simultaneous: `rx_ready` pulse coincides with word completion → `rx_valid` stays 1 with the new data and `overrun` stays 0.

Source files
------------

// File: rtl/spi_slave_ctrl.sv
// Oversampled SPI slave: all four SPI modes, configurable word width and bit order,
// one-entry TX buffer, RX holding register and sticky overrun/underrun/abort flags.
module spi_slave_ctrl #(
    parameter int WIDTH       = 32,
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0,
    parameter bit MSB_FIRST   = 1'b1,
    parameter int SYNC_STAGES = 3
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             sclk,
    input  logic             ss_n,
    input  logic             mosi,
    output logic             miso,
    output logic             miso_oe,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             frame_active,
    output logic             overrun,
    output logic             underrun,
    output logic             aborted,
    input  logic             clear_flags
);
    localparam int CW          = $clog2(WIDTH);
    localparam bit SAMPLE_RISE = (CPOL == CPHA);
    localparam int LAST        = SYNC_STAGES - 1;

    typedef enum logic [1:0] {IDLE, START, SHIFT} state_t;
    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
    logic [WIDTH-1:0]       tx_shift, tx_buf, rx_shift, rx_word;
    logic                   tx_full, armed, reload_pend;
    logic [CW-1:0]          bit_cnt;
    logic                   sclk_rise, sclk_fall, ss_fall, ss_rise, in_shift;
    logic                   sample_edge, drive_edge, word_done;
    logic                   start_load, abort_set, tx_load, tx_accept;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync <= {SYNC_STAGES{CPOL}};
            ss_sync   <= '1;
            mosi_sync <= '0;
        end else begin
            sclk_sync <= {sclk_sync[LAST-1:0], sclk};
            ss_sync   <= {ss_sync[LAST-1:0], ss_n};
            mosi_sync <= {mosi_sync[LAST-1:0], mosi};
        end
    end

    // Edges are taken between the two oldest synchroniser stages.
    assign sclk_rise   = sclk_sync[LAST-1] & ~sclk_sync[LAST];
    assign sclk_fall   = ~sclk_sync[LAST-1] & sclk_sync[LAST];
    assign ss_fall     = ss_sync[LAST] & ~ss_sync[LAST-1];
    assign ss_rise     = ~ss_sync[LAST] & ss_sync[LAST-1];
    assign in_shift    = (state == SHIFT) & ~ss_sync[LAST] & ~ss_sync[LAST-1];
    assign sample_edge = in_shift & (SAMPLE_RISE ? sclk_rise : sclk_fall);
    assign drive_edge  = in_shift & (SAMPLE_RISE ? sclk_fall : sclk_rise);
    assign word_done   = sample_edge & (bit_cnt == CW'(WIDTH - 1));

    assign rx_word = MSB_FIRST ? {rx_shift[WIDTH-2:0], mosi_sync[LAST]}
                               : {mosi_sync[LAST], rx_shift[WIDTH-1:1]};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_next = state;
        start_load = 1'b0;
        abort_set  = 1'b0;
        unique case (state)
            IDLE:  if (ss_fall) state_next = START;
            START: begin
                start_load = 1'b1;
                state_next = SHIFT;
            end
            SHIFT: if (ss_rise) begin
                state_next = IDLE;
                abort_set  = (bit_cnt != '0);
            end
            default: state_next = IDLE;
        endcase
    end

    // CPHA=0 reloads on the drive edge after completion so the last bit stays on MISO.
    assign tx_load   = start_load | (CPHA ? word_done : (drive_edge & reload_pend));
    assign tx_accept = tx_valid & ~tx_full;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tx_shift    <= '0;
            tx_buf      <= '0;
            tx_full     <= 1'b0;
            rx_shift    <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            bit_cnt     <= '0;
            armed       <= 1'b0;
            reload_pend <= 1'b0;
            overrun     <= 1'b0;
            underrun    <= 1'b0;
            aborted     <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout, so every term reads the pre-edge value.
            if (tx_load)
                tx_shift <= tx_full ? tx_buf : '0;
            else if (drive_edge && armed)
                tx_shift <= MSB_FIRST ? {tx_shift[WIDTH-2:0], 1'b0}
                                      : {1'b0, tx_shift[WIDTH-1:1]};

            if (tx_accept) tx_buf <= tx_data;
            tx_full <= tx_accept | (tx_full & ~tx_load);

            if (start_load || word_done) bit_cnt <= '0;
            else if (sample_edge)        bit_cnt <= bit_cnt + 1'b1;

            if (sample_edge) rx_shift <= rx_word;
            if (word_done)   rx_data  <= rx_word;
            rx_valid <= word_done | (rx_valid & ~rx_ready);

            // CPHA=1 leaves the fresh word unarmed so its first leading edge does not shift.
            if (start_load || drive_edge) armed <= 1'b0;
            else if (sample_edge)         armed <= ~(word_done & CPHA);

            if (start_load || drive_edge) reload_pend <= 1'b0;
            else if (word_done)           reload_pend <= 1'b1;

            overrun  <= (word_done & rx_valid & ~rx_ready) | (overrun & ~clear_flags);
            underrun <= (tx_load & ~tx_full) | (underrun & ~clear_flags);
            aborted  <= abort_set | (aborted & ~clear_flags);
        end
    end

    assign miso         = (state == IDLE) ? 1'b0 : (MSB_FIRST ? tx_shift[WIDTH-1] : tx_shift[0]);
    assign miso_oe      = ~ss_sync[LAST];
    assign frame_active = ~ss_sync[LAST];
    assign tx_ready     = ~tx_full;
endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Bench for spi_slave_ctrl: three instances (mode 0/W32/MSB, mode 3/W16/LSB, mode 1/W32/MSB)
// driven by a bit-level SPI master; received words are checked by a scoreboard monitor.
module tb_spi_slave_ctrl;
    localparam int H = 6;  // SCLK half period in system clocks

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    logic [2:0]        sclk, ss_n, mosi, tx_valid, rx_ready, clear_flags;
    logic [2:0][63:0]  tx_data;
    wire  [2:0]        miso, miso_oe, tx_ready, rx_valid, frame_active, overrun, underrun, aborted;
    wire  [31:0]       rx_d0, rx_d2;
    wire  [15:0]       rx_d1;

    spi_slave_ctrl #(.WIDTH(32), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1), .SYNC_STAGES(3)) u_m0 (
        .clock(clock), .reset_n(reset_n), .sclk(sclk[0]), .ss_n(ss_n[0]), .mosi(mosi[0]),
        .miso(miso[0]), .miso_oe(miso_oe[0]), .tx_data(tx_data[0][31:0]), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready[0]), .rx_data(rx_d0), .rx_valid(rx_valid[0]), .rx_ready(rx_ready[0]),
        .frame_active(frame_active[0]), .overrun(overrun[0]), .underrun(underrun[0]),
        .aborted(aborted[0]), .clear_flags(clear_flags[0]));

    spi_slave_ctrl #(.WIDTH(16), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0), .SYNC_STAGES(3)) u_m3 (
        .clock(clock), .reset_n(reset_n), .sclk(sclk[1]), .ss_n(ss_n[1]), .mosi(mosi[1]),
        .miso(miso[1]), .miso_oe(miso_oe[1]), .tx_data(tx_data[1][15:0]), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready[1]), .rx_data(rx_d1), .rx_valid(rx_valid[1]), .rx_ready(rx_ready[1]),
        .frame_active(frame_active[1]), .overrun(overrun[1]), .underrun(underrun[1]),
        .aborted(aborted[1]), .clear_flags(clear_flags[1]));

    spi_slave_ctrl #(.WIDTH(32), .CPOL(1'b0), .CPHA(1'b1), .MSB_FIRST(1'b1), .SYNC_STAGES(3)) u_m1 (
        .clock(clock), .reset_n(reset_n), .sclk(sclk[2]), .ss_n(ss_n[2]), .mosi(mosi[2]),
        .miso(miso[2]), .miso_oe(miso_oe[2]), .tx_data(tx_data[2][31:0]), .tx_valid(tx_valid[2]),
        .tx_ready(tx_ready[2]), .rx_data(rx_d2), .rx_valid(rx_valid[2]), .rx_ready(rx_ready[2]),
        .frame_active(frame_active[2]), .overrun(overrun[2]), .underrun(underrun[2]),
        .aborted(aborted[2]), .clear_flags(clear_flags[2]));

    typedef struct packed {
        logic [1:0]  idx;
        logic [63:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int  width_of(input int idx); return (idx == 1) ? 16 : 32; endfunction
    function automatic logic cpol_of(input int idx); return idx == 1;             endfunction
    function automatic logic cpha_of(input int idx); return idx != 0;             endfunction
    function automatic logic msb_of(input int idx);  return idx != 1;             endfunction

    function automatic logic [63:0] rx_word(input int idx);
        case (idx)
            0:       return {32'h0, rx_d0};
            1:       return {48'h0, rx_d1};
            default: return {32'h0, rx_d2};
        endcase
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic load_tx(input int idx, input logic [63:0] data);
        int budget = 200;
        while (!tx_ready[idx] && budget > 0) begin
            @(negedge clock);
            budget--;
        end
        tests++;
        if (budget == 0) begin
            fails++;
            $display("FAIL tx_ready_timeout: inst %0d tx_ready stayed %b, required 1", idx, tx_ready[idx]);
        end
        tx_data[idx]  = data;
        tx_valid[idx] = 1'b1;
        @(negedge clock);
        tx_valid[idx] = 1'b0;
    endtask

    task automatic consume(input int idx);
        rx_ready[idx] = 1'b1;
        @(negedge clock);
        rx_ready[idx] = 1'b0;
    endtask

    task automatic pulse_clear(input int idx);
        clear_flags[idx] = 1'b1;
        @(negedge clock);
        clear_flags[idx] = 1'b0;
    endtask

    task automatic ss_low(input int idx);
        ss_n[idx] = 1'b0;
        wait_clk(H);
    endtask

    task automatic ss_high(input int idx);
        wait_clk(H);
        ss_n[idx] = 1'b1;
        wait_clk(H);
    endtask

    // Master: shifts nbits of data out on MOSI and returns what it sampled on MISO.
    // With pulse set, rx_ready is raised for exactly the cycle the last sample edge completes the word.
    task automatic xfer(input int idx, input logic [63:0] data, input int nbits,
                        input bit pulse, output logic [63:0] rd);
        int   w;
        logic cpol, b;
        w    = width_of(idx);
        cpol = cpol_of(idx);
        rd   = '0;
        for (int i = 0; i < nbits; i++) begin
            int pos = msb_of(idx) ? (w - 1 - i) : i;
            if (cpha_of(idx)) begin
                sclk[idx] = ~cpol;
                mosi[idx] = data[pos];
                wait_clk(H);
                b = miso[idx];
                sclk[idx] = cpol;
            end else begin
                mosi[idx] = data[pos];
                wait_clk(H);
                b = miso[idx];
                sclk[idx] = ~cpol;
            end
            if (pulse && i == nbits - 1) begin
                wait_clk(2);
                rx_ready[idx] = 1'b1;
                wait_clk(1);
                rx_ready[idx] = 1'b0;
                wait_clk(H - 3);
            end else begin
                wait_clk(H);
            end
            if (!cpha_of(idx)) sclk[idx] = cpol;
            if (msb_of(idx)) rd = {rd[62:0], b};
            else             rd[i] = b;
        end
    endtask

    // Scoreboard monitor: every consumer handshake must match the next expected word.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            #2;
            for (int i = 0; i < 3; i++) begin
                if (reset_n && rx_valid[i] && rx_ready[i]) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL rx_unexpected: inst %0d delivered %h, none expected", i, rx_word(i));
                    end else begin
                        e = exp_q.pop_front();
                        check("rx_inst", 64'(i), 64'(e.idx));
                        check("rx_data", rx_word(i), e.data);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [63:0] rd, rd2;
        sclk        = 3'b010;
        ss_n        = 3'b111;
        mosi        = '0;
        tx_valid    = '0;
        rx_ready    = '0;
        clear_flags = '0;
        tx_data     = '0;
        reset_n     = 1'b0;
        wait_clk(5);
        reset_n = 1'b1;
        wait_clk(3);

        check("reset_miso_oe_active", {miso, miso_oe, frame_active}, 0);
        check("reset_tx_ready", 64'(tx_ready), 64'h7);
        check("reset_rx_valid_flags", {rx_valid, overrun, underrun, aborted}, 0);
        check("reset_rx_data", {rx_d0, rx_d1, rx_d2}, 0);

        // Mode 0, one 32-bit word; a filler word keeps the post-word reload fed.
        load_tx(0, 64'hDEADBEEF);
        exp_q.push_back('{idx: 2'd0, data: 64'h12345678});
        rx_ready[0] = 1'b1;
        ss_low(0);
        check("m0_frame_active", 64'(frame_active[0]), 1);
        check("m0_buffer_taken", 64'(tx_ready[0]), 1);
        load_tx(0, 64'h0);
        xfer(0, 64'h12345678, 32, 1'b0, rd);
        check("m0_miso_word", rd, 64'hDEADBEEF);
        ss_high(0);
        rx_ready[0] = 1'b0;
        check("m0_flags", {overrun[0], underrun[0], aborted[0]}, 0);
        check("m0_rx_valid_done", 64'(rx_valid[0]), 0);

        // Mode 3, 16-bit LSB first, two words back to back, rx_ready tied high.
        rx_ready[1] = 1'b1;
        load_tx(1, 64'hA5A5);
        exp_q.push_back('{idx: 2'd1, data: 64'hA5A5});
        exp_q.push_back('{idx: 2'd1, data: 64'h0F0F});
        ss_low(1);
        load_tx(1, 64'h0F0F);
        xfer(1, 64'hA5A5, 16, 1'b0, rd);
        load_tx(1, 64'h0);
        xfer(1, 64'h0F0F, 16, 1'b0, rd2);
        ss_high(1);
        check("m3_miso_word1", rd, 64'hA5A5);
        check("m3_miso_word2", rd2, 64'h0F0F);
        check("m3_flags", {overrun[1], underrun[1], aborted[1]}, 0);

        // Overrun: two words with the consumer stalled; only the second survives.
        exp_q.push_back('{idx: 2'd0, data: 64'h2});
        ss_low(0);
        xfer(0, 64'h1, 32, 1'b0, rd);
        xfer(0, 64'h2, 32, 1'b0, rd);
        ss_high(0);
        check("ovr_rx_data", rx_word(0), 64'h2);
        check("ovr_rx_valid", 64'(rx_valid[0]), 1);
        check("ovr_flag", 64'(overrun[0]), 1);
        pulse_clear(0);
        check("ovr_cleared", {overrun[0], underrun[0], aborted[0]}, 0);
        consume(0);
        wait_clk(2);

        // Underrun and abort: empty buffer, frame dropped after 10 bits.
        ss_low(0);
        xfer(0, 64'hFFFFFFFF, 10, 1'b0, rd);
        ss_high(0);
        check("abort_miso_zero", rd, 64'h0);
        check("abort_underrun", 64'(underrun[0]), 1);
        check("abort_aborted", 64'(aborted[0]), 1);
        check("abort_no_rx", 64'(rx_valid[0]), 0);
        pulse_clear(0);

        // Reset in the middle of a mode 1 word.
        load_tx(2, 64'h5A5A5A5A);
        ss_low(2);
        xfer(2, 64'hCAFEF00D, 5, 1'b0, rd);
        reset_n = 1'b0;
        ss_n[2] = 1'b1;
        wait_clk(2);
        check("rst_mid_miso_oe_active", {miso, miso_oe, frame_active}, 0);
        check("rst_mid_tx_ready", 64'(tx_ready), 64'h7);
        check("rst_mid_rx_flags", {rx_valid, overrun, underrun, aborted}, 0);
        check("rst_mid_rx_data", 64'(rx_d2), 0);
        reset_n = 1'b1;
        wait_clk(H);
        load_tx(2, 64'h13579BDF);
        exp_q.push_back('{idx: 2'd2, data: 64'hCAFEF00D});
        rx_ready[2] = 1'b1;
        ss_low(2);
        load_tx(2, 64'h0);
        xfer(2, 64'hCAFEF00D, 32, 1'b0, rd);
        ss_high(2);
        rx_ready[2] = 1'b0;
        check("m1_miso_word", rd, 64'h13579BDF);
        check("m1_flags", {overrun[2], underrun[2], aborted[2]}, 0);

        // rx_ready pulse coincides with completion of the second word.
        exp_q.push_back('{idx: 2'd0, data: 64'h11112222});
        exp_q.push_back('{idx: 2'd0, data: 64'h33334444});
        ss_low(0);
        xfer(0, 64'h11112222, 32, 1'b0, rd);
        xfer(0, 64'h33334444, 32, 1'b1, rd);
        check("sim_rx_valid", 64'(rx_valid[0]), 1);
        check("sim_rx_data", rx_word(0), 64'h33334444);
        check("sim_no_overrun", 64'(overrun[0]), 0);
        ss_high(0);
        consume(0);
        wait_clk(4);

        check("scoreboard_drained", 64'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
